// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode constants, class codes, decoded bundle layout and
// decode helpers for the instruction decode stage.
package decode_pkg;

    // Primary opcodes (top three bits of the instruction word)
    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_CALL = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // Widths of the default configuration (16-bit instruction words)
    localparam int DEF_REG_AW = 3;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_MOV  = 3'd1,
        CLS_ALU  = 3'd2,
        CLS_LDR  = 3'd3,
        CLS_STR  = 3'd4,
        CLS_BR   = 3'd5,
        CLS_CALL = 3'd6,
        CLS_HALT = 3'd7
    } instr_class_e;

    // Decoded bundle at the default widths. The stage builds the same field
    // order at its own parameterised widths.
    typedef struct packed {
        logic [2:0]            opcode;
        logic [1:0]            op;
        logic [DEF_REG_AW-1:0] rn;
        logic [DEF_REG_AW-1:0] rd;
        logic [1:0]            sh;
        logic [DEF_REG_AW-1:0] rm;
        logic [DEF_DATA_W-1:0] imm8;
        logic [DEF_DATA_W-1:0] imm5;
        instr_class_e          cls;
        logic                  illegal;
    } decoded_t;

    // Sign-extend field[msb:0] to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext_imm(input logic [7:0] field, input logic [2:0] msb);
        logic [63:0] mask;
        logic [63:0] wide;
        mask = (64'd1 << ({61'd0, msb} + 64'd1)) - 64'd1;
        wide = {56'd0, field} & mask;
        return field[msb] ? (wide | ~mask) : wide;
    endfunction

    // Class of an opcode/op pair; CLS_NOP marks an undefined encoding.
    function automatic instr_class_e classify(input logic [2:0] opc, input logic [1:0] op);
        instr_class_e cls;
        cls = CLS_NOP;
        case (opc)
            OPC_MOV:  if (op == 2'b10 || op == 2'b00) cls = CLS_MOV;
            OPC_ALU:  cls = CLS_ALU;
            OPC_LDR:  if (op == 2'b00) cls = CLS_LDR;
            OPC_STR:  if (op == 2'b00) cls = CLS_STR;
            OPC_BR:   if (op == 2'b00) cls = CLS_BR;
            OPC_CALL: if (op != 2'b01) cls = CLS_CALL;
            OPC_HALT: cls = CLS_HALT;
            default:  cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: generic 2-entry valid/ready skid buffer with synchronous
// flush. The head entry drives the outputs directly; the skid entry only
// fills when the head stalls during an input transfer. in_ready is registered.
module dec_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_head_valid;
    logic [W-1:0] r_head_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         r_in_ready;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_head_valid & out_ready;

    // Head entry: refilled from skid when draining at occupancy 2, otherwise
    // loaded by an input transfer whenever it is empty or draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_xfer) r_head_data <= r_skid_data;
        end else if (w_in_xfer && (!r_head_valid || w_out_xfer)) begin
            r_head_valid <= 1'b1;
            r_head_data  <= in_data;
        end else if (w_out_xfer) begin
            r_head_valid <= 1'b0;
        end
    end

    // Skid entry and registered in_ready (ready exactly when skid is empty).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (r_skid_valid) begin
            if (w_out_xfer) begin
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (w_in_xfer && r_head_valid && !w_out_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_head_valid;
    assign out_data  = r_head_data;

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered instruction decode stage. Splits the raw
// word into fields, classifies it, sign-extends immediates and hands the
// bundle plus PC tag to register fetch through a 2-entry skid buffer.
// Optional build macro DECODE_PERF_CNT_EN adds saturating perf counters.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int REG_AW  = 3,
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_opcode,
    output logic [1:0]         out_op,
    output logic [REG_AW-1:0]  out_rn,
    output logic [REG_AW-1:0]  out_rd,
    output logic [1:0]         out_sh,
    output logic [REG_AW-1:0]  out_rm,
    output logic [DATA_W-1:0]  out_imm8,
    output logic [DATA_W-1:0]  out_imm5,
    output logic [2:0]         out_class,
    output logic               out_illegal,
`ifdef DECODE_PERF_CNT_EN
    output logic [31:0]        perf_decoded,
    output logic [31:0]        perf_stall,
`endif
    output logic [PC_W-1:0]    out_pc
);

    // Reject configurations whose field layout cannot be formed
    if (INSTR_W != 7 + 3 * REG_AW) begin : g_bad_instr_w
        $error("INSTR_W must equal 7 + 3*REG_AW");
    end
    if (DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
        $error("DATA_W must be in 8..64");
    end

    localparam int RN_LSB = 2 * REG_AW + 2;
    localparam int RD_LSB = REG_AW + 2;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [1:0]        op;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rd;
        logic [1:0]        sh;
        logic [REG_AW-1:0] rm;
        logic [DATA_W-1:0] imm8;
        logic [DATA_W-1:0] imm5;
        instr_class_e      cls;
        logic              illegal;
    } dec_bundle_t;

    localparam int PAYLOAD_W = $bits(dec_bundle_t) + PC_W;

    dec_bundle_t            w_dec;
    dec_bundle_t            w_out_dec;
    logic [PAYLOAD_W-1:0]   w_in_payload;
    logic [PAYLOAD_W-1:0]   w_out_payload;
    logic [PC_W-1:0]        w_out_pc;
    logic                   w_out_valid;

    // Combinational decode of the incoming word
    always_comb begin
        w_dec         = '0;
        w_dec.opcode  = in_instr[INSTR_W-1 -: 3];
        w_dec.op      = in_instr[INSTR_W-4 -: 2];
        w_dec.rn      = in_instr[RN_LSB +: REG_AW];
        w_dec.rd      = in_instr[RD_LSB +: REG_AW];
        w_dec.sh      = in_instr[REG_AW +: 2];
        w_dec.rm      = in_instr[REG_AW-1:0];
        w_dec.imm8    = DATA_W'(sext_imm(in_instr[7:0], 3'd7));
        w_dec.imm5    = DATA_W'(sext_imm({3'b000, in_instr[4:0]}, 3'd4));
        w_dec.cls     = classify(w_dec.opcode, w_dec.op);
        w_dec.illegal = (w_dec.cls == CLS_NOP);
    end

    assign w_in_payload = {w_dec, in_pc};

    dec_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {w_out_dec, w_out_pc} = w_out_payload;

    assign out_valid   = w_out_valid;
    assign out_opcode  = w_out_dec.opcode;
    assign out_op      = w_out_dec.op;
    assign out_rn      = w_out_dec.rn;
    assign out_rd      = w_out_dec.rd;
    assign out_sh      = w_out_dec.sh;
    assign out_rm      = w_out_dec.rm;
    assign out_imm8    = w_out_dec.imm8;
    assign out_imm5    = w_out_dec.imm5;
    assign out_class   = w_out_dec.cls;
    assign out_illegal = w_out_dec.illegal;
    assign out_pc      = w_out_pc;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_perf_decoded;
    logic [31:0] r_perf_stall;

    // Saturating count of output transfers; survives flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_decoded <= '0;
        end else if (w_out_valid && out_ready && !(&r_perf_decoded)) begin
            r_perf_decoded <= r_perf_decoded + 32'd1;
        end
    end

    // Saturating count of stalled output cycles; survives flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
        end else if (w_out_valid && !out_ready && !(&r_perf_stall)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_decoded = r_perf_decoded;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered, parametrised instruction decode pipeline stage with valid/ready handshakes on both sides.
- Accepts raw instruction words from fetch and splits them into opcode, op, Rn, Rd, sh and Rm fields.
- Classifies each instruction, sign-extends its immediates, and flags illegal encodings.
- Presents the decoded bundle to register fetch through a 2-entry skid buffer, so backpressure never drops or duplicates a word.

Parameters:
- REG_AW, 3: register-index width; INSTR_W = 7 + 3*REG_AW (16 at default); elaboration error otherwise.
- DATA_W, 16: width of sign-extended immediates; must be >= 8.
- PC_W, 8: width of the PC tag carried alongside each instruction.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept a word
- in_instr  in  INSTR_W  raw instruction
- in_pc  in  PC_W  PC tag
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_opcode  out  3  instr[INSTR_W-1 -: 3]
- out_op  out  2  next 2 bits
- out_rn  out  REG_AW  next REG_AW bits
- out_rd  out  REG_AW  next REG_AW bits
- out_sh  out  2  next 2 bits
- out_rm  out  REG_AW  low REG_AW bits
- out_imm8  out  DATA_W  sign-extended instr[7:0]
- out_imm5  out  DATA_W  sign-extended instr[4:0]
- out_class  out  3  instruction class code, see Behaviour
- out_illegal  out  1  encoding not defined
- out_pc  out  PC_W  PC tag passed through unchanged

Behaviour:
- Reset:
  - Async assert clears both buffer entries.
  - out_valid=0, in_ready=1, all data outputs 0, out_class=CLS_NOP (0).
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Output data is held stable while out_valid & !out_ready.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 if the output register is empty or draining that cycle.
- Buffer occupancy is 0, 1 or 2 entries; the output register is always the head.
  - in_ready = (occupancy < 2), registered.
  - Occupancy goes 2 only when the output register stalls during an input transfer; the skid entry refills the head on the next output transfer.
  - Simultaneous input and output transfer at occupancy 1: occupancy stays 1; the new word replaces the head.
  - Full throughput: one word per cycle sustained while out_ready=1.
- Flush (synchronous, priority over all transfers):
  - Next edge: occupancy = 0, out_valid = 0, in_ready = 1.
  - A word presented in the flush cycle is discarded.
  - Flush while occupancy = 0 has no effect.
- Decode is combinational on in_instr and stored into the entry. Classes, keyed on opcode/op:
  - 110/10 and 110/00 -> CLS_MOV (1)
  - 101/xx -> CLS_ALU (2)
  - 011/00 -> CLS_LDR (3)
  - 100/00 -> CLS_STR (4)
  - 001/00 -> CLS_BR (5)
  - 010/11, 010/00, 010/10 -> CLS_CALL (6)
  - 111/xx -> CLS_HALT (7)
  - Any other combination -> CLS_NOP (0) with out_illegal = 1.
- Immediates: imm8 = {{DATA_W-8{instr[7]}}, instr[7:0]}; imm5 is built the same way from instr[4].
- An illegal word is still passed downstream with its field outputs populated; this stage never stalls on it.
- Reset asserted mid-transfer: in-flight words are lost; no output glitch beyond the async clear.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined, adds outputs perf_decoded (32 bits) and perf_stall (32 bits):
  - perf_decoded counts output transfers.
  - perf_stall counts cycles with out_valid & !out_ready.
  - Both saturate at all-ones, are cleared by reset, and are not cleared by flush.
- When not defined, neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, ...).
  - instr_class_e enum (3 bits).
  - decoded_t packed struct of all out_* data fields.
  - Function sext_imm.
- One sub-module: dec_skid_buf.
  - Generic 2-entry valid/ready skid buffer parametrised on payload width, with a flush input.
  - The top level instantiates it with payload = decoded_t + PC.

Test Plan:
- 16'b110_10_010_00000101 with out_ready=1 -> next cycle: out_class=1, rn=2, imm8=0x0005, out_illegal=0.
- ALU 16'b101_00_001_010_01_011 followed by 16'b110_10_000_11111110 -> opcode=5, rn=1, rd=2, sh=1, rm=3 for the first word; imm8=0xFFFE for the second.
- 16'b000_00_... -> out_class=0, out_illegal=1, word still transfers.
- out_ready held low while 3 words are offered -> in_ready drops after 2 are accepted; release out_ready -> words emerge in order, no loss or duplication.
- Occupancy 2 with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flush-cycle word never appears.
- Reset asserted mid-stream between clock edges -> out_valid falls immediately; perf counters (if DECODE_PERF_CNT_EN) read 0.
